// File: rtl/ball_pkg.sv
// Shared definitions for the ball tracker: grid geometry, cell characters
// and the tracker state encoding.
package ball_pkg;

  localparam int         GRID_DIM   = 16;
  localparam logic [7:0] CHAR_BALL  = 8'h6F;  // "o"
  localparam logic [7:0] CHAR_EMPTY = 8'h5F;  // "_"

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } tracker_state_t;

  // True when a cell holds the background character.
  function automatic logic is_empty_cell(input logic [7:0] c);
    return c == CHAR_EMPTY;
  endfunction

endpackage

// File: rtl/ball_velocity_est.sv
// Frame-to-frame ball velocity estimator. Keeps the previous found position
// and produces new-minus-previous deltas whenever a frame result is committed.
// Only instantiated when BALL_TRACKER_VELOCITY_EN is defined.
module ball_velocity_est (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              update,
  input  logic              found,
  input  logic [3:0]        pos_x,
  input  logic [3:0]        pos_y,
  output logic signed [4:0] vel_x,
  output logic signed [4:0] vel_y
);

  logic              prev_found_q, prev_found_d;
  logic [3:0]        prev_x_q, prev_x_d;
  logic [3:0]        prev_y_q, prev_y_d;
  logic signed [4:0] vel_x_q, vel_x_d;
  logic signed [4:0] vel_y_q, vel_y_d;

  // On a committed frame compute deltas (only if both frames saw the ball)
  // and remember this frame's position for the next one.
  always_comb begin
    prev_found_d = prev_found_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    vel_x_d      = vel_x_q;
    vel_y_d      = vel_y_q;
    if (update) begin
      if (found && prev_found_q) begin
        vel_x_d = $signed({1'b0, pos_x}) - $signed({1'b0, prev_x_q});
        vel_y_d = $signed({1'b0, pos_y}) - $signed({1'b0, prev_y_q});
      end else begin
        vel_x_d = 5'sd0;
        vel_y_d = 5'sd0;
      end
      prev_found_d = found;
      if (found) begin
        prev_x_d = pos_x;
        prev_y_d = pos_y;
      end
    end
  end

  // History and velocity registers.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      prev_found_q <= 1'b0;
      prev_x_q     <= 4'd0;
      prev_y_q     <= 4'd0;
      vel_x_q      <= 5'sd0;
      vel_y_q      <= 5'sd0;
    end else begin
      prev_found_q <= prev_found_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      vel_x_q      <= vel_x_d;
      vel_y_q      <= vel_y_d;
    end
  end

  assign vel_x = vel_x_q;
  assign vel_y = vel_y_q;

endmodule

// File: rtl/ball_tracker.sv
// Ball tracker: scans a 16x16 character grid streamed row-major, reports the
// first ball cell of each complete frame, flags multiple hits and aborted
// frames. Velocity output is built only with BALL_TRACKER_VELOCITY_EN.
module ball_tracker #(
  parameter logic [7:0] OBJ_CHAR = ball_pkg::CHAR_BALL,
  parameter int         GRID_DIM = ball_pkg::GRID_DIM
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              cell_valid,
  output logic              cell_ready,
  input  logic [7:0]        cell_char,
  input  logic              cell_sof,
  output logic              pos_valid,
  output logic              ball_found,
  output logic [3:0]        ball_position_x,
  output logic [3:0]        ball_position_y,
  output logic signed [4:0] ball_velocity_x,
  output logic signed [4:0] ball_velocity_y,
  output logic              multi_hit,
  output logic              frame_error
);

  import ball_pkg::*;

  localparam logic [7:0] LAST_CELL = 8'(GRID_DIM * GRID_DIM - 1);

  tracker_state_t state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;

  // Partial results of the frame currently being scanned.
  logic       acc_found_q, acc_found_d;
  logic       acc_multi_q, acc_multi_d;
  logic [3:0] acc_x_q, acc_x_d;
  logic [3:0] acc_y_q, acc_y_d;

  // Published results of the last completed frame.
  logic       res_found_q, res_found_d;
  logic       res_multi_q, res_multi_d;
  logic [3:0] res_x_q, res_x_d;
  logic [3:0] res_y_q, res_y_d;

  logic       frame_error_q, frame_error_d;

  logic       accept;
  logic       is_ball;
  logic       commit;
  logic       scan_found, scan_multi;
  logic [3:0] scan_x, scan_y;

  assign cell_ready = (state_q != ST_REPORT);
  assign accept     = cell_valid && cell_ready;
  assign is_ball    = (cell_char == OBJ_CHAR);

  // Next-state, cell counting, hit accumulation and result commit.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_found_d   = acc_found_q;
    acc_multi_d   = acc_multi_q;
    acc_x_d       = acc_x_q;
    acc_y_d       = acc_y_q;
    res_found_d   = res_found_q;
    res_multi_d   = res_multi_q;
    res_x_d       = res_x_q;
    res_y_d       = res_y_q;
    frame_error_d = 1'b0;
    commit        = 1'b0;
    scan_found    = acc_found_q;
    scan_multi    = acc_multi_q;
    scan_x        = acc_x_q;
    scan_y        = acc_y_q;

    case (state_q)
      ST_IDLE: begin
        // Only a start-of-frame cell opens a scan; it is cell (0,0).
        if (accept && cell_sof) begin
          state_d     = ST_SCAN;
          cnt_d       = 8'd1;
          acc_found_d = is_ball;
          acc_multi_d = 1'b0;
          acc_x_d     = 4'd0;
          acc_y_d     = 4'd0;
        end
      end
      ST_SCAN: begin
        if (accept) begin
          if (cell_sof) begin
            // Early start-of-frame: drop the partial frame and restart here.
            frame_error_d = 1'b1;
            cnt_d         = 8'd1;
            acc_found_d   = is_ball;
            acc_multi_d   = 1'b0;
            acc_x_d       = 4'd0;
            acc_y_d       = 4'd0;
          end else begin
            if (is_ball) begin
              if (acc_found_q) begin
                scan_multi = 1'b1;
              end else begin
                scan_found = 1'b1;
                scan_x     = cnt_q[3:0];
                scan_y     = cnt_q[7:4];
              end
            end
            if (cnt_q == LAST_CELL) begin
              commit      = 1'b1;
              state_d     = ST_REPORT;
              cnt_d       = 8'd0;
              res_found_d = scan_found;
              res_multi_d = scan_multi;
              if (scan_found) begin
                res_x_d = scan_x;
                res_y_d = scan_y;
              end
              acc_found_d = 1'b0;
              acc_multi_d = 1'b0;
              acc_x_d     = 4'd0;
              acc_y_d     = 4'd0;
            end else begin
              cnt_d       = cnt_q + 8'd1;
              acc_found_d = scan_found;
              acc_multi_d = scan_multi;
              acc_x_d     = scan_x;
              acc_y_d     = scan_y;
            end
          end
        end
      end
      default: begin
        // REPORT lasts a single cycle.
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter, accumulator and result registers.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      acc_found_q   <= 1'b0;
      acc_multi_q   <= 1'b0;
      acc_x_q       <= 4'd0;
      acc_y_q       <= 4'd0;
      res_found_q   <= 1'b0;
      res_multi_q   <= 1'b0;
      res_x_q       <= 4'd0;
      res_y_q       <= 4'd0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_found_q   <= acc_found_d;
      acc_multi_q   <= acc_multi_d;
      acc_x_q       <= acc_x_d;
      acc_y_q       <= acc_y_d;
      res_found_q   <= res_found_d;
      res_multi_q   <= res_multi_d;
      res_x_q       <= res_x_d;
      res_y_q       <= res_y_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign pos_valid       = (state_q == ST_REPORT);
  assign ball_found      = res_found_q;
  assign multi_hit       = res_multi_q;
  assign ball_position_x = res_x_q;
  assign ball_position_y = res_y_q;
  assign frame_error     = frame_error_q;

`ifdef BALL_TRACKER_VELOCITY_EN
  ball_velocity_est u_vel (
    .clk_50 (clk_50),
    .reset  (reset),
    .update (commit),
    .found  (res_found_d),
    .pos_x  (res_x_d),
    .pos_y  (res_y_d),
    .vel_x  (ball_velocity_x),
    .vel_y  (ball_velocity_y)
  );
`else
  logic unused_commit;
  assign unused_commit   = commit;
  assign ball_velocity_x = 5'sd0;
  assign ball_velocity_y = 5'sd0;
`endif

endmodule

// File: tb/tb_ball_tracker.sv
// Self-checking bench for ball_tracker: directed frames, aborted frame,
// random frames with valid gaps, and a mid-frame reset.
module tb_ball_tracker;

  logic              clk_50 = 1'b0;
  logic              reset;
  logic              cell_valid;
  logic              cell_ready;
  logic [7:0]        cell_char;
  logic              cell_sof;
  logic              pos_valid;
  logic              ball_found;
  logic [3:0]        ball_position_x;
  logic [3:0]        ball_position_y;
  logic signed [4:0] ball_velocity_x;
  logic signed [4:0] ball_velocity_y;
  logic              multi_hit;
  logic              frame_error;

  ball_tracker dut (
    .clk_50          (clk_50),
    .reset           (reset),
    .cell_valid      (cell_valid),
    .cell_ready      (cell_ready),
    .cell_char       (cell_char),
    .cell_sof        (cell_sof),
    .pos_valid       (pos_valid),
    .ball_found      (ball_found),
    .ball_position_x (ball_position_x),
    .ball_position_y (ball_position_y),
    .ball_velocity_x (ball_velocity_x),
    .ball_velocity_y (ball_velocity_y),
    .multi_hit       (multi_hit),
    .frame_error     (frame_error)
  );

  always #5 clk_50 = ~clk_50;

  int errors = 0;
  int checks = 0;
  int pv_count = 0;
  int fe_count = 0;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk_50) begin
    if (pos_valid)   pv_count++;
    if (frame_error) fe_count++;
  end

  logic [7:0] frame_mem [256];

  // Reference model state.
  logic              exp_found, exp_multi;
  logic [3:0]        exp_x, exp_y;
  logic signed [4:0] exp_vx, exp_vy;
  logic              m_prev_found;
  int                m_prev_x, m_prev_y;

  task automatic model_reset();
    exp_found = 0; exp_multi = 0; exp_x = 0; exp_y = 0;
    exp_vx = 0; exp_vy = 0;
    m_prev_found = 0; m_prev_x = 0; m_prev_y = 0;
  endtask

  // Expected frame result from a whole-frame view of frame_mem.
  task automatic model_frame();
    int first = -1;
    int hits = 0;
    for (int i = 0; i < 256; i++) begin
      if (frame_mem[i] == ball_pkg::CHAR_BALL) begin
        if (first < 0) first = i;
        hits++;
      end
    end
    exp_found = (hits > 0);
    exp_multi = (hits > 1);
    exp_vx = 0;
    exp_vy = 0;
    if (hits > 0) begin
      exp_x = 4'(first % 16);
      exp_y = 4'(first / 16);
`ifdef BALL_TRACKER_VELOCITY_EN
      if (m_prev_found) begin
        exp_vx = 5'((first % 16) - m_prev_x);
        exp_vy = 5'((first / 16) - m_prev_y);
      end
`endif
      m_prev_x = first % 16;
      m_prev_y = first / 16;
    end
    m_prev_found = (hits > 0);
  endtask

  task automatic fill_empty();
    for (int i = 0; i < 256; i++) frame_mem[i] = ball_pkg::CHAR_EMPTY;
  endtask

  task automatic fill_random();
    logic [7:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 8'($urandom_range(32, 126));
      if (c == ball_pkg::CHAR_BALL) c = ball_pkg::CHAR_EMPTY;
      frame_mem[i] = c;
    end
  endtask

  task automatic put_ball(input int x, input int y);
    frame_mem[y * 16 + x] = ball_pkg::CHAR_BALL;
  endtask

  // Streams frame_mem as one frame and checks the report cycle.
  task automatic run_frame(input string name, input int gap_pct, input bit expect_abort);
    int pvb = pv_count;
    int feb = fe_count;
    model_frame();
    for (int i = 0; i < 256; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        cell_valid = 0;
        cell_sof   = 0;
        repeat ($urandom_range(1, 3)) @(posedge clk_50);
        #1;
      end
      cell_valid = 1;
      cell_char  = frame_mem[i];
      cell_sof   = (i == 0);
      @(posedge clk_50);
      #1;
      if (i == 0) begin
        checks++;
        if (frame_error !== expect_abort) begin
          errors++;
          $display("FAIL %s frame_error_at_sof got=%0b want=%0b", name, frame_error, expect_abort);
        end
      end
    end
    cell_valid = 0;
    cell_sof   = 0;
    checks++;
    if (pos_valid !== 1'b1) begin errors++; $display("FAIL %s pos_valid_latency got=%0b want=1", name, pos_valid); end
    checks++;
    if (cell_ready !== 1'b0) begin errors++; $display("FAIL %s ready_in_report got=%0b want=0", name, cell_ready); end
    checks++;
    if (pv_count != pvb) begin errors++; $display("FAIL %s early_pos_valid got=%0d want=%0d", name, pv_count, pvb); end
    checks++;
    if (ball_found !== exp_found) begin errors++; $display("FAIL %s ball_found got=%0b want=%0b", name, ball_found, exp_found); end
    checks++;
    if (multi_hit !== exp_multi) begin errors++; $display("FAIL %s multi_hit got=%0b want=%0b", name, multi_hit, exp_multi); end
    checks++;
    if ({ball_position_x, ball_position_y} !== {exp_x, exp_y}) begin
      errors++;
      $display("FAIL %s position got=(%0d,%0d) want=(%0d,%0d)", name, ball_position_x, ball_position_y, exp_x, exp_y);
    end
    checks++;
    if ({ball_velocity_x, ball_velocity_y} !== {exp_vx, exp_vy}) begin
      errors++;
      $display("FAIL %s velocity got=(%0d,%0d) want=(%0d,%0d)", name, ball_velocity_x, ball_velocity_y, exp_vx, exp_vy);
    end
    $display("frame %s: found=%0b multi=%0b pos=(%0d,%0d) vel=(%0d,%0d)", name, ball_found, multi_hit,
             ball_position_x, ball_position_y, ball_velocity_x, ball_velocity_y);
    @(posedge clk_50);
    #1;
    checks++;
    if (pos_valid !== 1'b0 || cell_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_report got=pv%0b/rdy%0b want=pv0/rdy1", name, pos_valid, cell_ready);
    end
    checks++;
    if (pv_count != pvb + 1 || fe_count != feb + int'(expect_abort)) begin
      errors++;
      $display("FAIL %s pulse_counts got=pv%0d/fe%0d want=pv%0d/fe%0d", name, pv_count - pvb, fe_count - feb,
               1, int'(expect_abort));
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if ({pos_valid, frame_error, ball_found, multi_hit, ball_position_x, ball_position_y,
         ball_velocity_x, ball_velocity_y} !== 22'd0 || cell_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s reset_outputs got=pv%0b fe%0b f%0b m%0b (%0d,%0d) v(%0d,%0d) rdy%0b want=all0 rdy1",
               name, pos_valid, frame_error, ball_found, multi_hit, ball_position_x, ball_position_y,
               ball_velocity_x, ball_velocity_y, cell_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1; cell_valid = 0; cell_char = 0; cell_sof = 0;
    repeat (3) @(posedge clk_50);
    #1;
    check_zero_outputs("reset");
    reset = 0;
    @(posedge clk_50);
    #1;
    model_reset();
    $display("reset: outputs cleared");
  endtask

  task automatic test_motion();
    fill_empty(); put_ball(4, 0);  run_frame("single_4_0", 0, 0);
    fill_empty(); put_ball(8, 4);  run_frame("move_8_4", 0, 0);
    fill_empty(); put_ball(0, 15); run_frame("move_0_15", 0, 0);
  endtask

  task automatic test_multi_and_empty();
    fill_empty(); put_ball(3, 2); put_ball(9, 9); run_frame("multi_3_2", 0, 0);
    fill_empty(); run_frame("empty", 0, 0);
    fill_empty(); put_ball(15, 15); run_frame("last_cell", 0, 0);
  endtask

  task automatic test_sof_abort();
    fill_empty(); put_ball(5, 1);
    cell_valid = 1;
    for (int i = 0; i < 100; i++) begin
      cell_char = frame_mem[i];
      cell_sof  = (i == 0);
      @(posedge clk_50);
      #1;
    end
    fill_empty(); put_ball(7, 12);
    run_frame("abort_restart", 0, 1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      fill_random();
      repeat ($urandom_range(0, 3)) put_ball($urandom_range(0, 15), $urandom_range(0, 15));
      run_frame($sformatf("random_%0d", f), 30, 0);
    end
  endtask

  task automatic test_reset_mid();
    int pvb, feb;
    fill_empty(); put_ball(2, 2); run_frame("pre_reset", 0, 0);
    fill_random(); put_ball(1, 0);
    pvb = pv_count;
    feb = fe_count;
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(99) < 30) begin
        cell_valid = 0; cell_sof = 0;
        @(posedge clk_50);
        #1;
      end
      cell_valid = 1; cell_char = frame_mem[i]; cell_sof = (i == 0);
      @(posedge clk_50);
      #1;
    end
    reset = 1;
    cell_valid = 0;
    cell_sof = 0;
    #1;
    check_zero_outputs("reset_mid");
    @(posedge clk_50);
    #1;
    reset = 0;
    model_reset();
    cell_valid = 1;
    for (int i = 0; i < 20; i++) begin
      cell_char = (i % 2 == 0) ? ball_pkg::CHAR_BALL : ball_pkg::CHAR_EMPTY;
      cell_sof  = 0;
      @(posedge clk_50);
      #1;
    end
    cell_valid = 0;
    repeat (2) @(posedge clk_50);
    #1;
    checks++;
    if (pv_count != pvb || fe_count != feb) begin
      errors++;
      $display("FAIL reset_mid pulses got=pv%0d/fe%0d want=pv0/fe0", pv_count - pvb, fe_count - feb);
    end
    check_zero_outputs("ignored_cells");
    fill_empty(); put_ball(6, 9); run_frame("post_reset", 20, 0);
  endtask

  task automatic test_back_to_back();
    fill_empty(); put_ball(10, 3); run_frame("b2b_a", 0, 0);
    fill_empty(); put_ball(0, 0);  run_frame("b2b_b", 0, 0);
    fill_empty(); put_ball(15, 0); put_ball(0, 1); run_frame("b2b_c", 0, 0);
  endtask

  initial begin
    test_reset();
    test_motion();
    test_multi_and_empty();
    test_sof_abort();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
